// File: rtl/seq_deser_pkg.sv
// Shared types and sizing for the 1-bit to 8-slot deserializer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package seq_deser_pkg;

    localparam int NSLOTS = 8;
    localparam int CNT_W  = 3;

    typedef enum logic {
        RECV = 1'b0,
        SEND = 1'b1
    } state_t;

    // One-hot write enable for the slot addressed by sel.
    function automatic logic [NSLOTS-1:0] slot_decode(input logic [CNT_W-1:0] sel);
        slot_decode      = '0;
        slot_decode[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/seq_deser_slot_ctr.sv
// Slot pointer: 3-bit counter with enable, natural wrap 7->0, and last flag.
// Latency: count updates on the clock edge after en; last is combinational from cnt.
// Backpressure: none; holds its value while en is low.
module seq_deser_slot_ctr
    import seq_deser_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(NSLOTS - 1));

endmodule

// File: rtl/seq_deser_1b_1to8.sv
// Deserializer: eight accepted bits land in out0..out7, then the group is offered on out_val/out_rdy.
// Latency: slot visible 1 cycle after its transfer; out_val 1 cycle after the 8th transfer.
// Backpressure: in_rdy low while a full group waits; out_rdy low holds the group indefinitely.
module seq_deser_1b_1to8
    import seq_deser_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in_val,
    output logic in_rdy,
    input  logic in,
    output logic out_val,
    input  logic out_rdy,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4,
    output logic out5,
    output logic out6,
    output logic out7
);

    state_t             state;
    state_t             next_state;
    logic               in_xfer;
    logic               last;
    logic [CNT_W-1:0]   cnt;
    logic [NSLOTS-1:0]  slot_we;
    logic [NSLOTS-1:0]  slots;

    assign in_xfer = in_val && in_rdy;

    seq_deser_slot_ctr u_slot_ctr (
        .clk   (clk),
        .reset (reset),
        .en    (in_xfer),
        .cnt   (cnt),
        .last  (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RECV;
        end else begin
            state <= next_state;
        end
    end

    // Handshake outputs depend on state only, so neither ready nor valid
    // ever combinationally follows the opposite side's request.
    always_comb begin
        next_state = state;
        in_rdy     = 1'b0;
        out_val    = 1'b0;
        case (state)
            RECV: begin
                in_rdy = 1'b1;
                if (in_val && last) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                out_val = 1'b1;
                if (out_rdy) begin
                    next_state = RECV;
                end
            end
            default: begin
                next_state = RECV;
            end
        endcase
    end

    assign slot_we = in_xfer ? slot_decode(cnt) : '0;

    // Slots are not cleared between groups; each is simply overwritten in turn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots <= '0;
        end else begin
            for (int i = 0; i < NSLOTS; i++) begin
                if (slot_we[i]) begin
                    slots[i] <= in;
                end
            end
        end
    end

    assign out0 = slots[0];
    assign out1 = slots[1];
    assign out2 = slots[2];
    assign out3 = slots[3];
    assign out4 = slots[4];
    assign out5 = slots[5];
    assign out6 = slots[6];
    assign out7 = slots[7];

endmodule

// File: tb/tb_seq_deser_1b_1to8.sv
// Bench for seq_deser_1b_1to8: directed groups plus random stalls, groups checked by a queue-based monitor.
module tb_seq_deser_1b_1to8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_val = 1'b0;
    logic din = 1'b0;
    logic out_rdy = 1'b0;
    logic in_rdy, out_val;
    logic out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0] outs;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] shadow = 8'h00;
    bit rand_rdy = 1'b0;

    assign outs = {out7, out6, out5, out4, out3, out2, out1, out0};

    always #5 clk = ~clk;

    seq_deser_1b_1to8 dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in      (din),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out0    (out0),
        .out1    (out1),
        .out2    (out2),
        .out3    (out3),
        .out4    (out4),
        .out5    (out5),
        .out6    (out6),
        .out7    (out7)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offers one bit until accepted; returns at #1 after the accepting edge with in_val still high.
    task automatic send_bit(input logic b);
        bit acc;
        int t;
        in_val = 1'b1;
        din    = b;
        acc    = 1'b0;
        t      = 0;
        while (!acc && t < 200) begin
            acc = in_rdy;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) chk("accept_timeout", 8'd0, 8'd1);
    endtask

    task automatic idle(input int n);
        in_val = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_group(input logic [7:0] bits, input int max_gap);
        logic [7:0] model;
        model = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(bits[i]);
            model     = {bits[i], model[7:1]};
            shadow[i] = bits[i];
            chk("slot_write", outs, shadow);
            chk("out_val_after_bit", {7'd0, out_val}, (i == 7) ? 8'd1 : 8'd0);
            if (i < 7 && max_gap > 0) idle($urandom_range(0, max_gap));
        end
        in_val = 1'b0;
        exp_q.push_back(model);
    endtask

    task automatic release_group();
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        chk("turnaround_in_rdy", {7'd0, in_rdy}, 8'd1);
        chk("turnaround_out_val", {7'd0, out_val}, 8'd0);
    endtask

    // Monitor: each new presentation of out_val consumes one expected group.
    initial begin
        logic prev;
        logic [7:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (out_val && !prev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_group", 8'd1, 8'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("group", outs, e);
                        chk("in_rdy_in_send", {7'd0, in_rdy}, 8'd0);
                    end
                end
                prev = out_val;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        #2 reset = 1'b1;
        #1;
        chk("reset_in_rdy", {7'd0, in_rdy}, 8'd1);
        chk("reset_out_val", {7'd0, out_val}, 8'd0);
        chk("reset_slots", outs, 8'h00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("idle_in_rdy", {7'd0, in_rdy}, 8'd1);
            chk("idle_out_val", {7'd0, out_val}, 8'd0);
            chk("idle_slots", outs, 8'h00);
        end

        // Back-to-back 1,0,1,1,0,0,1,0 then hold with out_rdy low
        send_group(8'h4D, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("hold_out_val", {7'd0, out_val}, 8'd1);
            chk("hold_in_rdy", {7'd0, in_rdy}, 8'd0);
            chk("hold_slots", outs, 8'h4D);
        end
        release_group();
        chk("slots_kept", outs, 8'h4D);

        // One-hot at slot 5 with gaps
        send_group(8'h20, 3);

        // Bits offered while a group waits must be ignored
        in_val = 1'b1;
        din    = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("send_ignore_slots", outs, 8'h20);
            chk("send_ignore_out_val", {7'd0, out_val}, 8'd1);
        end
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        in_val  = 1'b0;
        out_rdy = 1'b0;
        chk("simul_in_rdy", {7'd0, in_rdy}, 8'd1);
        chk("simul_slots", outs, 8'h20);
        send_group(8'h81, 0);
        release_group();

        // Reset after 4 accepted bits discards the partial group
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
            shadow[i] = 1'b1;
        end
        in_val = 1'b0;
        chk("partial_slots", outs, shadow);
        #2 reset = 1'b1;
        #1;
        chk("midreset_slots", outs, 8'h00);
        chk("midreset_in_rdy", {7'd0, in_rdy}, 8'd1);
        chk("midreset_out_val", {7'd0, out_val}, 8'd0);
        shadow = 8'h00;
        @(posedge clk);
        #1 reset = 1'b0;
        send_group(8'h96, 1);
        release_group();

        // Random groups with random input gaps and output stalls
        rand_rdy = 1'b1;
        for (int g = 0; g < 20; g++) begin
            send_group(8'($urandom), 2);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 out_rdy = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b0;
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
